// File: rtl/branch_unit.sv
// branch_unit: decode-stage branch resolution with operand forwarding,
// plus a fetch-stage 2-bit saturating-counter branch history table (BHT).
// Optional statistics counters are built only when BRANCH_UNIT_STATS_EN is
// defined; otherwise the counter outputs are constant zero.
module branch_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int PC_WIDTH   = 32,
    parameter int BHT_DEPTH  = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PC_WIDTH-1:0]   pc_if,
    output logic                  predict_taken,
    input  logic                  branch_id,
    input  logic                  stall_id,
    input  logic [PC_WIDTH-1:0]   pc_id,
    input  logic                  predicted_id,
    input  logic [2:0]            branch_type,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [DATA_WIDTH-1:0] read1,
    input  logic [DATA_WIDTH-1:0] read2,
    input  logic [4:0]            rd_ex,
    input  logic [4:0]            rd_mem,
    input  logic [4:0]            rd_wb,
    input  logic                  reg_write_ex,
    input  logic                  reg_write_mem,
    input  logic                  reg_write_wb,
    input  logic [DATA_WIDTH-1:0] alu_out_ex,
    input  logic [DATA_WIDTH-1:0] alu_out_mem,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  branch_taken,
    output logic                  mispredict,
    output logic                  illegal_type,
    output logic [CNT_WIDTH-1:0]  branch_count,
    output logic [CNT_WIDTH-1:0]  mispredict_count
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    // Youngest in-flight producer wins; register x0 is never forwarded.
    function automatic logic [DATA_WIDTH-1:0] fwd_operand(
        input logic [4:0]            rs,
        input logic [DATA_WIDTH-1:0] rf_data
    );
        if (reg_write_ex && (rd_ex != 5'd0) && (rd_ex == rs)) begin
            return alu_out_ex;
        end else if (reg_write_mem && (rd_mem != 5'd0) && (rd_mem == rs)) begin
            return alu_out_mem;
        end else if (reg_write_wb && (rd_wb != 5'd0) && (rd_wb == rs)) begin
            return wb_data;
        end else begin
            return rf_data;
        end
    endfunction

    logic [DATA_WIDTH-1:0] w_op_a;
    logic [DATA_WIDTH-1:0] w_op_b;
    logic                  w_cmp;
    logic                  w_update;
    logic [IDX_W-1:0]      w_idx_if;
    logic [IDX_W-1:0]      w_idx_id;
    logic [1:0]            r_bht [BHT_DEPTH];
    logic                  w_unused_pc;

    assign w_op_a   = fwd_operand(rs1, read1);
    assign w_op_b   = fwd_operand(rs2, read2);
    assign w_idx_if = pc_if[IDX_W+1:2];
    assign w_idx_id = pc_id[IDX_W+1:2];
    assign w_unused_pc = ^{pc_if[PC_WIDTH-1:IDX_W+2], pc_if[1:0],
                           pc_id[PC_WIDTH-1:IDX_W+2], pc_id[1:0]};

    // Evaluate the branch condition selected by funct3.
    always_comb begin
        w_cmp = 1'b0;
        case (branch_type)
            3'b000:  w_cmp = (w_op_a == w_op_b);
            3'b001:  w_cmp = (w_op_a != w_op_b);
            3'b100:  w_cmp = ($signed(w_op_a) <  $signed(w_op_b));
            3'b101:  w_cmp = ($signed(w_op_a) >= $signed(w_op_b));
            3'b110:  w_cmp = (w_op_a <  w_op_b);
            3'b111:  w_cmp = (w_op_a >= w_op_b);
            default: w_cmp = 1'b0;
        endcase
    end

    assign illegal_type  = branch_id & ((branch_type == 3'b010) | (branch_type == 3'b011));
    assign branch_taken  = branch_id & ~illegal_type & w_cmp;
    assign w_update      = branch_id & ~stall_id;
    assign mispredict    = w_update & (branch_taken ^ predicted_id);
    // Combinational read of the pre-edge table gives read-before-write.
    assign predict_taken = r_bht[w_idx_if][1];

    // Train the indexed 2-bit counter toward the resolved outcome, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (w_update) begin
            if (branch_taken && (r_bht[w_idx_id] != 2'b11)) begin
                r_bht[w_idx_id] <= r_bht[w_idx_id] + 2'b01;
            end else if (!branch_taken && (r_bht[w_idx_id] != 2'b00)) begin
                r_bht[w_idx_id] <= r_bht[w_idx_id] - 2'b01;
            end else begin
                r_bht[w_idx_id] <= r_bht[w_idx_id];
            end
        end else begin
            r_bht[w_idx_id] <= r_bht[w_idx_id];
        end
    end

`ifdef BRANCH_UNIT_STATS_EN
    logic [CNT_WIDTH-1:0] r_branch_count;
    logic [CNT_WIDTH-1:0] r_mispredict_count;

    // Count resolved branches and mispredictions, holding at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else if (w_update) begin
            if (r_branch_count != {CNT_WIDTH{1'b1}}) begin
                r_branch_count <= r_branch_count + CNT_WIDTH'(1);
            end else begin
                r_branch_count <= r_branch_count;
            end
            if (mispredict && (r_mispredict_count != {CNT_WIDTH{1'b1}})) begin
                r_mispredict_count <= r_mispredict_count + CNT_WIDTH'(1);
            end else begin
                r_mispredict_count <= r_mispredict_count;
            end
        end else begin
            r_branch_count     <= r_branch_count;
            r_mispredict_count <= r_mispredict_count;
        end
    end

    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;
`else
    assign branch_count     = '0;
    assign mispredict_count = '0;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Directed testbench for branch_unit (CNT_WIDTH=4 so counter saturation is short).
module tb_branch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] pc_if;
    logic        predict_taken;
    logic        branch_id;
    logic        stall_id;
    logic [31:0] pc_id;
    logic        predicted_id;
    logic [2:0]  branch_type;
    logic [4:0]  rs1, rs2;
    logic [31:0] read1, read2;
    logic [4:0]  rd_ex, rd_mem, rd_wb;
    logic        reg_write_ex, reg_write_mem, reg_write_wb;
    logic [31:0] alu_out_ex, alu_out_mem, wb_data;
    logic        branch_taken;
    logic        mispredict;
    logic        illegal_type;
    logic [3:0]  branch_count;
    logic [3:0]  mispredict_count;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef BRANCH_UNIT_STATS_EN
    localparam logic [31:0] EXP_SAT = 32'd15;
`else
    localparam logic [31:0] EXP_SAT = 32'd0;
`endif

    branch_unit #(
        .DATA_WIDTH(32), .PC_WIDTH(32), .BHT_DEPTH(64), .CNT_WIDTH(4)
    ) dut (
        .clk(clk), .rst(rst), .pc_if(pc_if), .predict_taken(predict_taken),
        .branch_id(branch_id), .stall_id(stall_id), .pc_id(pc_id),
        .predicted_id(predicted_id), .branch_type(branch_type),
        .rs1(rs1), .rs2(rs2), .read1(read1), .read2(read2),
        .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
        .reg_write_ex(reg_write_ex), .reg_write_mem(reg_write_mem),
        .reg_write_wb(reg_write_wb), .alu_out_ex(alu_out_ex),
        .alu_out_mem(alu_out_mem), .wb_data(wb_data),
        .branch_taken(branch_taken), .mispredict(mispredict),
        .illegal_type(illegal_type), .branch_count(branch_count),
        .mispredict_count(mispredict_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        branch_id = 1'b0; stall_id = 1'b0; pc_id = 32'h0; predicted_id = 1'b0;
        branch_type = 3'b000; rs1 = 5'd0; rs2 = 5'd0; read1 = 32'h0; read2 = 32'h0;
        rd_ex = 5'd0; rd_mem = 5'd0; rd_wb = 5'd0;
        reg_write_ex = 1'b0; reg_write_mem = 1'b0; reg_write_wb = 1'b0;
        alu_out_ex = 32'h0; alu_out_mem = 32'h0; wb_data = 32'h0;
    endtask

    // One unstalled branch at pc: taken via BEQ equal, not-taken via BNE equal.
    task automatic train(input logic [31:0] pc, input logic taken);
        set_idle();
        branch_id = 1'b1; pc_id = pc; read1 = 32'd5; read2 = 32'd5;
        branch_type = taken ? 3'b000 : 3'b001;
        step();
        set_idle();
        #1;
    endtask

    initial begin
        // Reset state
        rst = 1'b1; set_idle(); pc_if = 32'h40;
        step(); step();
        check_eq("rst_predict", predict_taken, 32'd0);
        check_eq("rst_taken", branch_taken, 32'd0);
        check_eq("rst_mispredict", mispredict, 32'd0);
        check_eq("rst_illegal", illegal_type, 32'd0);
        check_eq("rst_bcount", branch_count, 32'd0);
        check_eq("rst_mcount", mispredict_count, 32'd0);
        rst = 1'b0; #1;
        check_eq("lookup_0x40_initial", predict_taken, 32'd0);

        // First update of entry 0x40, same-cycle read-before-write
        branch_id = 1'b1; pc_id = 32'h40; branch_type = 3'b000;
        read1 = 32'd5; read2 = 32'd5; predicted_id = 1'b0; #1;
        check_eq("beq_taken", branch_taken, 32'd1);
        check_eq("beq_mispredict", mispredict, 32'd1);
        check_eq("rbw_predict", predict_taken, 32'd0);
        step(); set_idle(); #1;
        check_eq("lookup_0x40_after", predict_taken, 32'd1);

        // Forwarding priority (stalled so the table is untouched)
        stall_id = 1'b1; branch_id = 1'b1; pc_id = 32'h100; branch_type = 3'b000;
        rs1 = 5'd3; rd_ex = 5'd3; rd_mem = 5'd3; reg_write_ex = 1'b1; reg_write_mem = 1'b1;
        alu_out_ex = 32'd7; alu_out_mem = 32'd9; read1 = 32'd0; read2 = 32'd7; #1;
        check_eq("fwd_ex_priority", branch_taken, 32'd1);
        check_eq("stall_no_mispredict", mispredict, 32'd0);
        reg_write_ex = 1'b0; #1;
        check_eq("fwd_mem", branch_taken, 32'd0);
        reg_write_mem = 1'b0; reg_write_wb = 1'b1; rd_wb = 5'd3; wb_data = 32'd7; #1;
        check_eq("fwd_wb", branch_taken, 32'd1);
        rs2 = 5'd4; rd_ex = 5'd4; reg_write_ex = 1'b1; alu_out_ex = 32'd8; #1;
        check_eq("fwd_rs2_ex", branch_taken, 32'd0);

        // Signed vs unsigned, x0 forwarding ignored
        set_idle(); stall_id = 1'b1; branch_id = 1'b1;
        rs1 = 5'd0; rs2 = 5'd0; rd_ex = 5'd0; reg_write_ex = 1'b1; alu_out_ex = 32'd1;
        read1 = 32'hFFFF_FFFF; read2 = 32'd1;
        branch_type = 3'b100; #1; check_eq("blt", branch_taken, 32'd1);
        branch_type = 3'b110; #1; check_eq("bltu", branch_taken, 32'd0);
        branch_type = 3'b101; #1; check_eq("bge", branch_taken, 32'd0);
        branch_type = 3'b111; #1; check_eq("bgeu", branch_taken, 32'd1);
        branch_type = 3'b001; #1; check_eq("bne", branch_taken, 32'd1);

        // Illegal funct3
        set_idle(); branch_id = 1'b1; stall_id = 1'b1; read1 = 32'd5; read2 = 32'd5;
        branch_type = 3'b010; #1;
        check_eq("illegal_010", illegal_type, 32'd1);
        check_eq("illegal_010_taken", branch_taken, 32'd0);
        branch_type = 3'b011; #1;
        check_eq("illegal_011", illegal_type, 32'd1);
        branch_id = 1'b0; #1;
        check_eq("illegal_no_branch", illegal_type, 32'd0);

        // Stalled mismatching branch must not train entry 0x80
        set_idle(); pc_if = 32'h80; branch_id = 1'b1; stall_id = 1'b1; pc_id = 32'h80;
        read1 = 32'd1; read2 = 32'd1; predicted_id = 1'b0; #1;
        check_eq("stall_mispredict", mispredict, 32'd0);
        step(); set_idle(); #1;
        check_eq("stall_no_update", predict_taken, 32'd0);
        train(32'h80, 1'b1);
        check_eq("single_update_0x80", predict_taken, 32'd1);

        // Saturation: six taken then not-taken on entry 0xC0
        pc_if = 32'hC0;
        for (int i = 0; i < 6; i++) begin
            train(32'hC0, 1'b1);
            check_eq($sformatf("sat_taken_%0d", i), predict_taken, 32'd1);
        end
        train(32'hC0, 1'b0);
        check_eq("sat_nt_1", predict_taken, 32'd1);
        train(32'hC0, 1'b0);
        check_eq("sat_nt_2", predict_taken, 32'd0);

        // Statistics: 20 mispredicting branches
        for (int i = 0; i < 20; i++) begin
            set_idle(); branch_id = 1'b1; pc_id = 32'h200; branch_type = 3'b001;
            read1 = 32'd2; read2 = 32'd2; predicted_id = 1'b1;
            step();
        end
        set_idle(); #1;
        check_eq("bcount_sat", branch_count, EXP_SAT);
        check_eq("mcount_sat", mispredict_count, EXP_SAT);

        // Reset overrides an update in the same cycle
        pc_if = 32'h40; branch_id = 1'b1; pc_id = 32'h40; read1 = 32'd5; read2 = 32'd5;
        #2; rst = 1'b1;
        step();
        set_idle(); rst = 1'b0; #1;
        check_eq("midrst_predict", predict_taken, 32'd0);
        check_eq("midrst_bcount", branch_count, 32'd0);
        check_eq("midrst_mcount", mispredict_count, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
